// File: rtl/prog_loader_pkg.sv
// Shared loader types and frame constants for the program-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

    // Frame layout around the data payload: LEN_HI, LEN_LO ... CSUM
    localparam int HDR_LEN = 2;
    localparam int TRL_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CSUM    = 3'd5
    } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM write port of the loader.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the loader throttles the byte source.
interface prog_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;

    // Loader side: consumes the stream, drives the RAM write port
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    // Source side: drives the stream, observes the RAM write port
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );
endinterface

// File: rtl/prog_loader_byte_pair_assembler.sv
// Joins high/low bytes into a 16-bit word and keeps a running XOR of all bytes.
// Latency: word/word_vld registered, one cycle after the low byte is presented.
// Backpressure: none; the caller only strobes hi_en/lo_en on accepted bytes.
module byte_pair_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        word_vld,
    output logic [7:0]  csum
);

    logic [7:0] hi_q;

    // Latch high byte, emit the pair on the low byte, accumulate the checksum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= 8'h00;
            word     <= 16'h0000;
            word_vld <= 1'b0;
            csum     <= 8'h00;
        end else begin
            word_vld <= lo_en;
            if (hi_en) begin
                hi_q <= byte_in;
            end
            if (lo_en) begin
                word <= {hi_q, byte_in};
            end
            if (clr) begin
                csum <= 8'h00;
            end else if (hi_en || lo_en) begin
                csum <= csum ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Parses a length/data/checksum byte frame and writes words to program RAM from address 0.
// Latency: RAM write strobe one cycle after the low data byte is accepted; status on the CSUM edge.
// Backpressure: in_ready is high in every non-idle state, so the stream runs at one byte per cycle.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         cpu_hold
);

    ld_state_t state_q, state_d;

    logic [7:0]        len_hi_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              err_q;

    logic [15:0] len_now;
    logic        len_over;
    logic        last_word;
    logic [7:0]  csum;

    logic clr;
    logic ld_len_hi;
    logic ld_len_lo;
    logic hi_en;
    logic lo_en;
    logic set_done;
    logic set_err;

    assign len_now   = {len_hi_q, bus.in_data};
    // Counter is one bit wider than the address so that a full 2^ADDR_W image is legal
    assign len_over  = 32'(len_now) > (32'd1 << ADDR_W);
    assign last_word = (32'(cnt_q) + 32'd1) == 32'(n_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-byte control strobes
    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        ld_len_hi = 1'b0;
        ld_len_lo = 1'b0;
        hi_en     = 1'b0;
        lo_en     = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (bus.in_valid) begin
                    ld_len_hi = 1'b1;
                    state_d   = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (bus.in_valid) begin
                    ld_len_lo = 1'b1;
                    if (len_over) begin
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end else if (len_now == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (bus.in_valid) begin
                    hi_en   = 1'b1;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (bus.in_valid) begin
                    lo_en   = 1'b1;
                    state_d = last_word ? ST_CSUM : ST_DATA_HI;
                end
            end
            ST_CSUM: begin
                if (bus.in_valid) begin
                    if (bus.in_data == csum) begin
                        set_done = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Length capture, word counter, write address and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi_q <= 8'h00;
            n_q      <= 16'h0000;
            cnt_q    <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (clr) begin
                cnt_q  <= '0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (ld_len_hi) begin
                len_hi_q <= bus.in_data;
            end
            if (ld_len_lo) begin
                n_q <= len_now;
            end
            if (lo_en) begin
                addr_q <= cnt_q[ADDR_W-1:0];
                cnt_q  <= cnt_q + 1'b1;
            end
            if (set_done) begin
                done_q <= 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    byte_pair_assembler u_bpa (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .hi_en    (hi_en),
        .lo_en    (lo_en),
        .byte_in  (bus.in_data),
        .word     (bus.mem_wdata),
        .word_vld (bus.mem_we),
        .csum     (csum)
    );

    assign bus.mem_addr = addr_q;
    assign bus.in_ready = (state_q != ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign cpu_hold     = busy;
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst;
    logic start, start4;
    logic busy, done, error, cpu_hold;
    logic busy4, done4, error4, cpu_hold4;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(16)) bus ();
    prog_loader_if #(.ADDR_W(4))  bus4 ();

    prog_loader #(.ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    prog_loader #(.ADDR_W(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .bus      (bus4),
        .busy     (busy4),
        .done     (done4),
        .error    (error4),
        .cpu_hold (cpu_hold4)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int wn  = 0;
    int wn4 = 0;

    // Record every RAM write strobe seen on the falling edge
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wn < 64) begin
                wr_addr[wn] = bus.mem_addr;
                wr_data[wn] = bus.mem_wdata;
            end
            wn++;
        end
        if (bus4.mem_we === 1'b1) begin
            wn4++;
        end
    end

    logic [7:0] frm [$];

    // Pulse start, then send frm with 'gap' idle cycles before each byte;
    // a start pulse is injected in the first gap cycle before byte start_at
    task automatic run_frame(input int gap, input int start_at);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL start_clear: busy=%b done=%b error=%b, required 1 0 0", busy, done, error);
        end
        for (int i = 0; i < frm.size(); i++) begin
            for (int g = 0; g < gap; g++) begin
                start = (i == start_at && g == 0);
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            start = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = frm[i];
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b cpu_hold=%b in_ready=%b, required 0 0 0", busy, cpu_hold, bus.in_ready);
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem: we=%b addr=%h wdata=%h, required 0 0000 0000", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: done=%b error=%b, required 0 0", done, error);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_word();
        int base;
        base = wn;
        frm = '{8'h00, 8'h02, 8'h70, 8'h0F, 8'h80, 8'h02, 8'hFD};
        run_frame(0, -1);
        checks++;
        if (wn - base !== 2) begin
            errors++;
            $display("FAIL two_word_count: writes=%0d, required 2", wn - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 16'h700F) begin
                errors++;
                $display("FAIL two_word_w0: %h@%h, required 700f@0000", wr_data[base], wr_addr[base]);
            end
            checks++;
            if (wr_addr[base+1] !== 16'h0001 || wr_data[base+1] !== 16'h8002) begin
                errors++;
                $display("FAIL two_word_w1: %h@%h, required 8002@0001", wr_data[base+1], wr_addr[base+1]);
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL two_word_status: done=%b error=%b busy=%b in_ready=%b, required 1 0 0 0", done, error, busy, bus.in_ready);
        end
    endtask

    task automatic test_bad_csum();
        int base;
        base = wn;
        frm = '{8'h00, 8'h02, 8'h70, 8'h0F, 8'h80, 8'h02, 8'hFC};
        run_frame(0, -1);
        checks++;
        if (wn - base !== 2) begin
            errors++;
            $display("FAIL bad_csum_count: writes=%0d, required 2", wn - base);
        end else begin
            checks++;
            if (wr_data[base] !== 16'h700F || wr_data[base+1] !== 16'h8002 || wr_addr[base+1] !== 16'h0001) begin
                errors++;
                $display("FAIL bad_csum_words: %h %h@%h, required 700f 8002@0001", wr_data[base], wr_data[base+1], wr_addr[base+1]);
            end
        end
        checks++;
        if (done !== 1'b0 || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum_status: done=%b error=%b busy=%b, required 0 1 0", done, error, busy);
        end
    endtask

    task automatic test_empty();
        int base;
        base = wn;
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame(0, -1);
        checks++;
        if (wn - base !== 0 || done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL empty_good: writes=%0d done=%b error=%b, required 0 1 0", wn - base, done, error);
        end
        frm = '{8'h00, 8'h00, 8'h01};
        run_frame(0, -1);
        checks++;
        if (wn - base !== 0 || done !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL empty_bad: writes=%0d done=%b error=%b, required 0 0 1", wn - base, done, error);
        end
    endtask

    task automatic test_overflow();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = 8'h00;
        @(posedge clk); #1;
        bus4.in_data  = 8'h11;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        checks++;
        if (error4 !== 1'b1 || done4 !== 1'b0 || busy4 !== 1'b0 || bus4.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_status: error=%b done=%b busy=%b in_ready=%b, required 1 0 0 0", error4, done4, busy4, bus4.in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wn4 !== 0) begin
            errors++;
            $display("FAIL overflow_writes: writes=%0d, required 0", wn4);
        end
    endtask

    task automatic test_gapped();
        int base;
        base = wn;
        frm = '{8'h00, 8'h02, 8'h70, 8'h0F, 8'h80, 8'h02, 8'hFD};
        run_frame(2, 3);
        checks++;
        if (wn - base !== 2) begin
            errors++;
            $display("FAIL gapped_count: writes=%0d, required 2", wn - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 16'h700F ||
                wr_addr[base+1] !== 16'h0001 || wr_data[base+1] !== 16'h8002) begin
                errors++;
                $display("FAIL gapped_words: %h@%h %h@%h, required 700f@0000 8002@0001",
                         wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gapped_status: done=%b error=%b busy=%b, required 1 0 0", done, error, busy);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = wn;
        frm = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
        run_frame(0, -1);
        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        run_frame(0, -1);
        checks++;
        if (wn - base !== 2) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d, required 2", wn - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 16'hABCD ||
                wr_addr[base+1] !== 16'h0000 || wr_data[base+1] !== 16'h1234) begin
                errors++;
                $display("FAIL b2b_words: %h@%h %h@%h, required abcd@0000 1234@0000",
                         wr_data[base], wr_addr[base], wr_data[base+1], wr_addr[base+1]);
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_status: done=%b error=%b, required 1 0", done, error);
        end
    endtask

    task automatic test_rst_midload();
        int base;
        frm = '{8'h00, 8'h02, 8'h70, 8'h0F, 8'h80};
        run_frame(0, -1);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctl: busy=%b cpu_hold=%b in_ready=%b done=%b error=%b, required all 0",
                     busy, cpu_hold, bus.in_ready, done, error);
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_mem: we=%b addr=%h wdata=%h, required 0 0000 0000", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        base = wn;
        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        run_frame(0, -1);
        checks++;
        if (wn - base !== 1 || wr_addr[base] !== 16'h0000 || wr_data[base] !== 16'h1234) begin
            errors++;
            $display("FAIL rst_reload_write: writes=%0d first=%h@%h, required 1 1234@0000",
                     wn - base, wr_data[base], wr_addr[base]);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL rst_reload_status: done=%b error=%b, required 1 0", done, error);
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        start4        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus4.in_valid = 1'b0;
        bus4.in_data  = 8'h00;
        test_reset();
        test_two_word();
        test_bad_csum();
        test_empty();
        test_overflow();
        test_gapped();
        test_back_to_back();
        test_rst_midload();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
